// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge port of the MIPS memory-access stage.
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MIPS memory-access stage: issues LW/SW on a req/ack port, forwards other ALU results to writeback.
// state | meaning
// IDLE  | accepting instructions; non-memory results go straight to writeback
// BUSY  | request outstanding; waiting for dmem_ack or the ack timeout
module mem_access_stage #(
  parameter int TO_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [5:0]                 in_opcode,
  input  logic                       in_wr_en,
  input  logic [4:0]                 in_wr_addr,
  input  logic [31:0]                alu_rslt,
  input  logic [31:0]                store_data,
  output logic                       stall,
  mem_access_stage_if.master         dmem,
  output logic                       wb_en,
  output logic [4:0]                 wb_addr,
  output logic [31:0]                wb_data,
  output logic                       err_align,
  output logic                       err_bus
);

  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2b;
  // cnt_q holds the BUSY cycles already elapsed, so the (2**TO_W-1)th BUSY cycle sees 2**TO_W-2
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic [4:0]       wr_addr_q, wr_addr_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             wb_en_d;
  logic [4:0]       wb_addr_d;
  logic [31:0]      wb_data_d;
  logic             err_align_d, err_bus_d;
  logic             is_mem, aligned, timeout, stall_raw;

  assign is_mem  = (in_opcode == OP_LW) || (in_opcode == OP_SW);
  assign aligned = (alu_rslt[1:0] == 2'b00);
  assign timeout = (cnt_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_addr_d   = wr_addr_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wb_en_d     = 1'b0;
    wb_addr_d   = wb_addr;
    wb_data_d   = wb_data;
    err_align_d = 1'b0;
    err_bus_d   = 1'b0;
    stall_raw   = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_mem) begin
            if (aligned) begin
              stall_raw = 1'b1;
              req_d     = 1'b1;
              we_d      = (in_opcode == OP_SW);
              addr_d    = alu_rslt;
              wdata_d   = store_data;
              wr_addr_d = in_wr_addr;
              cnt_d     = '0;
              state_d   = BUSY;
            end else begin
              err_align_d = 1'b1;
            end
          end else begin
            wb_en_d   = in_wr_en && (in_wr_addr != 5'd0);
            wb_addr_d = in_wr_addr;
            wb_data_d = alu_rslt;
          end
        end
      end
      BUSY: begin
        cnt_d     = cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
        stall_raw = !dmem.dmem_ack && !timeout;
        // ack takes priority over a timeout landing in the same cycle
        if (dmem.dmem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
          if (!we_q) begin
            wb_en_d   = (wr_addr_q != 5'd0);
            wb_addr_d = wr_addr_q;
            wb_data_d = dmem.dmem_rdata;
          end
        end else if (timeout) begin
          req_d     = 1'b0;
          err_bus_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall = stall_raw && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_addr_q <= 5'd0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      wb_en     <= 1'b0;
      wb_addr   <= 5'd0;
      wb_data   <= 32'd0;
      err_align <= 1'b0;
      err_bus   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_addr_q <= wr_addr_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wb_en     <= wb_en_d;
      wb_addr   <= wb_addr_d;
      wb_data   <= wb_data_d;
      err_align <= err_align_d;
      err_bus   <= err_bus_d;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a short ack timeout (TO_W=3, 7 BUSY cycles).
module tb_mem_access_stage;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] OP_ADDU = 6'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [5:0]  in_opcode;
  logic        in_wr_en;
  logic [4:0]  in_wr_addr;
  logic [31:0] alu_rslt;
  logic [31:0] store_data;
  logic        stall;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        err_align;
  logic        err_bus;

  int checks = 0;
  int errors = 0;

  mem_access_stage_if dmem ();

  mem_access_stage #(.TO_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_opcode  (in_opcode),
    .in_wr_en   (in_wr_en),
    .in_wr_addr (in_wr_addr),
    .alu_rslt   (alu_rslt),
    .store_data (store_data),
    .stall      (stall),
    .dmem       (dmem),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .err_align  (err_align),
    .err_bus    (err_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic we,
                       input logic [4:0] wa, input logic [31:0] res, input logic [31:0] sd);
    in_valid   = v;
    in_opcode  = op;
    in_wr_en   = we;
    in_wr_addr = wa;
    alu_rslt   = res;
    store_data = sd;
  endtask

  initial begin
    int n_req, n_err, n_wb;
    logic stall_at_to;

    rst = 1'b1;
    drive(1'b1, OP_LW, 1'b1, 5'd5, 32'h100, 32'h0);
    dmem.dmem_ack   = 1'b0;
    dmem.dmem_rdata = 32'h0;
    tick();
    tick();
    chk("rst_stall", stall, 1'b0);
    chk("rst_req", dmem.dmem_req, 1'b0);
    chk("rst_addr", dmem.dmem_addr, 32'h0);
    chk("rst_wb_en", wb_en, 1'b0);
    chk("rst_wb_data", wb_data, 32'h0);
    drive(1'b0, OP_ADDU, 1'b0, 5'd0, 32'h0, 32'h0);
    rst = 1'b0;
    tick();

    // ADDU $3 = 0x10
    drive(1'b1, OP_ADDU, 1'b1, 5'd3, 32'h10, 32'h0);
    #1 chk("addu_stall", stall, 1'b0);
    tick();
    drive(1'b0, OP_ADDU, 1'b0, 5'd0, 32'h0, 32'h0);
    chk("addu_wb_en", wb_en, 1'b1);
    chk("addu_wb_addr", {27'd0, wb_addr}, 32'd3);
    chk("addu_wb_data", wb_data, 32'h10);
    tick();
    chk("addu_wb_pulse", wb_en, 1'b0);

    // LW $5 from 0x100, ack three cycles after req
    drive(1'b1, OP_LW, 1'b1, 5'd5, 32'h100, 32'h0);
    #1 chk("lw_accept_stall", stall, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("lw_req", dmem.dmem_req, 1'b1);
      chk("lw_we", dmem.dmem_we, 1'b0);
      chk("lw_addr", dmem.dmem_addr, 32'h100);
      chk("lw_busy_stall", stall, 1'b1);
      tick();
    end
    dmem.dmem_ack   = 1'b1;
    dmem.dmem_rdata = 32'hDEADBEEF;
    #1 chk("lw_ack_stall", stall, 1'b0);
    chk("lw_ack_req", dmem.dmem_req, 1'b1);
    tick();
    dmem.dmem_ack = 1'b0;
    drive(1'b0, OP_ADDU, 1'b0, 5'd0, 32'h0, 32'h0);
    chk("lw_done_req", dmem.dmem_req, 1'b0);
    chk("lw_wb_en", wb_en, 1'b1);
    chk("lw_wb_addr", {27'd0, wb_addr}, 32'd5);
    chk("lw_wb_data", wb_data, 32'hDEADBEEF);
    tick();
    chk("lw_wb_pulse", wb_en, 1'b0);

    // SW 0x1234 to 0x204, then LW $7 from 0x300 accepted the cycle after ack
    drive(1'b1, OP_SW, 1'b0, 5'd0, 32'h204, 32'h1234);
    tick();
    chk("sw_req", dmem.dmem_req, 1'b1);
    chk("sw_we", dmem.dmem_we, 1'b1);
    chk("sw_addr", dmem.dmem_addr, 32'h204);
    chk("sw_wdata", dmem.dmem_wdata, 32'h1234);
    dmem.dmem_ack = 1'b1;
    #1 chk("sw_ack_stall", stall, 1'b0);
    tick();
    dmem.dmem_ack = 1'b0;
    chk("sw_done_req", dmem.dmem_req, 1'b0);
    chk("sw_no_wb", wb_en, 1'b0);
    drive(1'b1, OP_LW, 1'b1, 5'd7, 32'h300, 32'h0);
    #1 chk("b2b_accept_stall", stall, 1'b1);
    tick();
    drive(1'b0, OP_ADDU, 1'b0, 5'd0, 32'h0, 32'h0);
    chk("b2b_req", dmem.dmem_req, 1'b1);
    chk("b2b_addr", dmem.dmem_addr, 32'h300);
    dmem.dmem_ack   = 1'b1;
    dmem.dmem_rdata = 32'hCAFE0001;
    tick();
    dmem.dmem_ack = 1'b0;
    chk("b2b_wb_en", wb_en, 1'b1);
    chk("b2b_wb_addr", {27'd0, wb_addr}, 32'd7);
    chk("b2b_wb_data", wb_data, 32'hCAFE0001);

    // misaligned LW
    drive(1'b1, OP_LW, 1'b1, 5'd5, 32'h102, 32'h0);
    #1 chk("align_stall", stall, 1'b0);
    tick();
    drive(1'b0, OP_ADDU, 1'b0, 5'd0, 32'h0, 32'h0);
    chk("align_err", err_align, 1'b1);
    chk("align_no_req", dmem.dmem_req, 1'b0);
    chk("align_no_wb", wb_en, 1'b0);
    tick();
    chk("align_err_pulse", err_align, 1'b0);
    chk("align_req_after", dmem.dmem_req, 1'b0);

    // LW with no ack: timeout after 7 BUSY cycles
    drive(1'b1, OP_LW, 1'b1, 5'd6, 32'h40, 32'h0);
    tick();
    drive(1'b0, OP_ADDU, 1'b0, 5'd0, 32'h0, 32'h0);
    n_req = 0; n_err = 0; n_wb = 0; stall_at_to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (dmem.dmem_req) begin
        n_req++;
        if (n_req == 7) stall_at_to = stall;
      end
      if (err_bus) n_err++;
      if (wb_en) n_wb++;
      tick();
    end
    chk("to_req_cycles", n_req, 32'd7);
    chk("to_err_pulses", n_err, 32'd1);
    chk("to_no_wb", n_wb, 32'd0);
    chk("to_stall_last", stall_at_to, 1'b0);

    // ack on the 7th BUSY cycle beats the timeout
    drive(1'b1, OP_LW, 1'b1, 5'd6, 32'h44, 32'h0);
    tick();
    drive(1'b0, OP_ADDU, 1'b0, 5'd0, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++) tick();
    chk("race_req", dmem.dmem_req, 1'b1);
    dmem.dmem_ack   = 1'b1;
    dmem.dmem_rdata = 32'h77;
    tick();
    dmem.dmem_ack = 1'b0;
    chk("race_no_err", err_bus, 1'b0);
    chk("race_wb_en", wb_en, 1'b1);
    chk("race_wb_data", wb_data, 32'h77);
    chk("race_req_low", dmem.dmem_req, 1'b0);

    // reset while BUSY, stray ack afterwards
    drive(1'b1, OP_LW, 1'b1, 5'd9, 32'h80, 32'h0);
    tick();
    drive(1'b0, OP_ADDU, 1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    chk("mid_req", dmem.dmem_req, 1'b1);
    rst = 1'b1;
    #1 chk("mid_rst_stall", stall, 1'b0);
    tick();
    rst = 1'b0;
    chk("mid_req_low", dmem.dmem_req, 1'b0);
    chk("mid_wb_en", wb_en, 1'b0);
    chk("mid_stall", stall, 1'b0);
    dmem.dmem_ack   = 1'b1;
    dmem.dmem_rdata = 32'hBAD;
    tick();
    dmem.dmem_ack = 1'b0;
    chk("stray_ack_wb", wb_en, 1'b0);
    chk("stray_ack_req", dmem.dmem_req, 1'b0);
    drive(1'b1, OP_LW, 1'b1, 5'd10, 32'h88, 32'h0);
    tick();
    drive(1'b0, OP_ADDU, 1'b0, 5'd0, 32'h0, 32'h0);
    chk("post_rst_addr", dmem.dmem_addr, 32'h88);
    dmem.dmem_ack   = 1'b1;
    dmem.dmem_rdata = 32'h5555;
    tick();
    dmem.dmem_ack = 1'b0;
    chk("post_rst_wb_en", wb_en, 1'b1);
    chk("post_rst_wb_addr", {27'd0, wb_addr}, 32'd10);
    chk("post_rst_wb_data", wb_data, 32'h5555);

    // LW to $0 never writes back
    drive(1'b1, OP_LW, 1'b1, 5'd0, 32'h8c, 32'h0);
    tick();
    drive(1'b0, OP_ADDU, 1'b0, 5'd0, 32'h0, 32'h0);
    chk("r0_req", dmem.dmem_req, 1'b1);
    dmem.dmem_ack   = 1'b1;
    dmem.dmem_rdata = 32'h1;
    tick();
    dmem.dmem_ack = 1'b0;
    chk("r0_no_wb", wb_en, 1'b0);
    chk("r0_req_low", dmem.dmem_req, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
